// File: rtl/eth_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkt_gen
// Brief    : Deterministic Ethernet frame generator producing 256-bit TX beats
//            (293-bit word: payload, mod, flags) for link bring-up/throughput.
// Revision : 1.0 - initial release
// ============================================================================
module eth_pkt_gen #(
  parameter int          LEN_MIN    = 64,
  parameter int          LEN_MAX    = 1518,
  parameter int          GAP_CYCLES = 0,
  parameter logic [47:0] DEST_MAC   = 48'h0000_0000_0001,
  parameter logic [47:0] SRC_MAC    = 48'h0000_0000_0002,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter logic [3:0]  TX_DEST    = 4'hF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         stop,
  input  logic [31:0]  num_pkts,
  input  logic         sweep_en,
  input  logic [13:0]  fixed_len,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic         tx_sop,
  output logic         tx_eop,
  output logic [292:0] tx_data,
  output logic [3:0]   tx_dest,
  output logic         busy,
  output logic         done,
  output logic [31:0]  pkt_count,
  output logic [47:0]  byte_count
);

  localparam logic [13:0]  c_LEN_MIN  = 14'(LEN_MIN);
  localparam logic [13:0]  c_LEN_MAX  = 14'(LEN_MAX);
  localparam logic [7:0]   c_GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [111:0] c_HDR      = {DEST_MAC, SRC_MAC, ETHERTYPE};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [31:0]  r_num_pkts;
  logic         r_sweep;
  logic [15:0]  r_seq;
  logic [13:0]  r_cur_len;
  logic [8:0]   r_beat;
  logic [7:0]   r_gap;
  logic         r_stop_pend;

  logic         w_start;
  logic         w_accept;
  logic         w_last_beat;
  logic         w_stop_eff;
  logic [31:0]  w_pkt_inc;
  logic         w_exit;
  logic [13:0]  w_start_len;
  logic [13:0]  w_next_len;
  logic [13:0]  w_cur_last;

  logic         w_load;
  logic         w_drop;
  logic         w_frame_end;
  logic         w_done_nxt;
  logic [15:0]  w_ld_seq;
  logic [13:0]  w_ld_len;
  logic [8:0]   w_ld_beat;
  logic [13:0]  w_ld_last;
  logic         w_ld_eop;
  logic [4:0]   w_ld_mod;
  logic [255:0] w_ld_payload;
  logic [13:0]  w_idx;
  logic [7:0]   w_byte;

  assign w_start     = (r_state == S_IDLE) && start;
  assign w_accept    = tx_valid && tx_ready;
  assign w_cur_last  = r_cur_len - 14'd1;
  assign w_last_beat = (r_beat == w_cur_last[13:5]);
  assign w_stop_eff  = r_stop_pend || stop;
  assign w_pkt_inc   = pkt_count + 32'd1;
  assign w_exit      = w_stop_eff || ((r_num_pkts != 32'd0) && (w_pkt_inc == r_num_pkts));

  always_comb begin
    w_start_len = fixed_len;
    if (sweep_en)                   w_start_len = c_LEN_MIN;
    else if (fixed_len < c_LEN_MIN) w_start_len = c_LEN_MIN;
    else if (fixed_len > c_LEN_MAX) w_start_len = c_LEN_MAX;
  end

  always_comb begin
    w_next_len = r_cur_len;
    if (r_sweep) w_next_len = (r_cur_len >= c_LEN_MAX) ? c_LEN_MIN : r_cur_len + 14'd1;
  end

  // Next state plus selection of which beat (seq, len, index) to register next
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_frame_end = 1'b0;
    w_done_nxt  = 1'b0;
    w_ld_seq    = r_seq;
    w_ld_len    = r_cur_len;
    w_ld_beat   = 9'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SEND;
          w_load      = 1'b1;
          w_ld_seq    = 16'd0;
          w_ld_len    = w_start_len;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          if (!w_last_beat) begin
            w_load    = 1'b1;
            w_ld_beat = r_beat + 9'd1;
          end else begin
            w_frame_end = 1'b1;
            if (w_exit) begin
              w_state_nxt = S_IDLE;
              w_drop      = 1'b1;
              w_done_nxt  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              w_state_nxt = S_GAP;
              w_drop      = 1'b1;
            end else begin
              w_load   = 1'b1;
              w_ld_seq = r_seq + 16'd1;
              w_ld_len = w_next_len;
            end
          end
        end
      end
      S_GAP: begin
        if (w_stop_eff) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_gap == c_GAP_LAST) begin
          w_state_nxt = S_SEND;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ld_last = w_ld_len - 14'd1;
  assign w_ld_eop  = (w_ld_beat == w_ld_last[13:5]);
  assign w_ld_mod  = w_ld_eop ? w_ld_len[4:0] : 5'd0;

  // Header bytes only fall in beat 0, since every frame is at least 60 bytes
  always_comb begin
    w_ld_payload = '0;
    w_idx        = '0;
    w_byte       = '0;
    for (int j = 0; j < 32; j++) begin
      w_idx = {w_ld_beat, 5'(j)};
      if (w_idx >= w_ld_len)                 w_byte = 8'd0;
      else if (w_ld_beat == 9'd0 && j < 14)  w_byte = c_HDR[111 - 8*j -: 8];
      else if (w_ld_beat == 9'd0 && j == 14) w_byte = w_ld_seq[15:8];
      else if (w_ld_beat == 9'd0 && j == 15) w_byte = w_ld_seq[7:0];
      else                                   w_byte = w_ld_seq[7:0] + w_idx[7:0];
      w_ld_payload[8*j +: 8] = w_byte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_valid    <= 1'b0;
      tx_sop      <= 1'b0;
      tx_eop      <= 1'b0;
      tx_data     <= '0;
      tx_dest     <= TX_DEST;
      busy        <= 1'b0;
      done        <= 1'b0;
      pkt_count   <= '0;
      byte_count  <= '0;
      r_num_pkts  <= '0;
      r_sweep     <= 1'b0;
      r_seq       <= '0;
      r_cur_len   <= '0;
      r_beat      <= '0;
      r_gap       <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      tx_dest <= TX_DEST;
      busy    <= (w_state_nxt != S_IDLE);
      done    <= w_done_nxt;
      r_gap   <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;

      if (r_state == S_IDLE || w_state_nxt == S_IDLE) r_stop_pend <= 1'b0;
      else if (stop)                                   r_stop_pend <= 1'b1;

      if (w_start) begin
        r_num_pkts <= num_pkts;
        r_sweep    <= sweep_en;
        r_seq      <= 16'd0;
        r_cur_len  <= w_start_len;
        pkt_count  <= '0;
        byte_count <= '0;
      end else if (w_frame_end) begin
        pkt_count  <= w_pkt_inc;
        byte_count <= byte_count + {34'd0, r_cur_len};
        r_seq      <= r_seq + 16'd1;
        r_cur_len  <= w_next_len;
      end

      if (w_load) begin
        tx_valid <= 1'b1;
        tx_sop   <= (w_ld_beat == 9'd0);
        tx_eop   <= w_ld_eop;
        tx_data  <= {32'd0, w_ld_mod, w_ld_payload};
        r_beat   <= w_ld_beat;
      end else if (w_drop) begin
        tx_valid <= 1'b0;
        tx_sop   <= 1'b0;
        tx_eop   <= 1'b0;
        tx_data  <= '0;
      end
    end
  end

endmodule
`default_nettype wire
